// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with a RUN-cycle prescaler, pause/abort control
// and rejection of non-BCD load values.
module bcd_countdown_timer #(
   parameter int TICK_DIV = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic [3:0] load_ones,
   input  logic [3:0] load_tens,
   output logic [3:0] count_ones,
   output logic [3:0] count_tens,
   output logic       busy,
   output logic       done,
   output logic       load_err
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   presc_reg, presc_next;
   logic [3:0]      ones_reg, ones_next;
   logic [3:0]      tens_reg, tens_next;
   logic            err_reg, err_next;
   logic            tick;
   logic            load_ok;

   assign tick    = (presc_reg == TICK_LAST);
   assign load_ok = (load_ones <= 4'd9) && (load_tens <= 4'd9);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         presc_reg <= '0;
         ones_reg  <= 4'd0;
         tens_reg  <= 4'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         presc_reg <= presc_next;
         ones_reg  <= ones_next;
         tens_reg  <= tens_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      presc_next = presc_reg;
      ones_next  = ones_reg;
      tens_next  = tens_reg;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (load_ok) begin
                  ones_next  = load_ones;
                  tens_next  = load_tens;
                  presc_next = '0;
                  state_next = (load_ones == 4'd0 && load_tens == 4'd0) ? DONE : RUN;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         RUN, PAUSED: begin
            // pause gates cycle by cycle: a cycle with pause low counts even
            // when it is the one that leaves PAUSED
            if (abort) begin
               ones_next  = 4'd0;
               tens_next  = 4'd0;
               presc_next = '0;
               state_next = IDLE;
            end else if (pause) begin
               state_next = PAUSED;
            end else begin
               state_next = RUN;
               presc_next = tick ? '0 : presc_reg + PW'(1);
               if (tick) begin
                  if (ones_reg != 4'd0) begin
                     ones_next = ones_reg - 4'd1;
                  end else begin
                     ones_next = 4'd9;
                     tens_next = tens_reg - 4'd1;
                  end
                  if (tens_reg == 4'd0 && ones_reg == 4'd1) state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign count_ones = ones_reg;
   assign count_tens = tens_reg;
   assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
   assign done       = (state_reg == DONE);
   assign load_err   = err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven bench for bcd_countdown_timer: one instance at TICK_DIV=1, one at
// TICK_DIV=4; expected outputs are queued when a vector is driven.
module tb_bcd_countdown_timer;

   typedef struct {
      string      name;
      logic       rst, st, pa, ab;
      logic [3:0] lt, lo;
      logic [3:0] et, eo;
      logic       eb, ed, ee;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start1 = 0, pause1 = 0, abort1 = 0;
   logic [3:0] lo1 = 0, lt1 = 0;
   logic [3:0] o1, t1;
   logic       b1, d1, e1;
   logic       start4 = 0, pause4 = 0, abort4 = 0;
   logic [3:0] lo4 = 0, lt4 = 0;
   logic [3:0] o4, t4;
   logic       b4, d4, e4;

   vec_t tbl[$];
   vec_t sb[$];
   int   applied = 0;
   int   miscompares = 0;

   always #5 clock = ~clock;

   bcd_countdown_timer #(.TICK_DIV(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .pause(pause1), .abort(abort1),
      .load_ones(lo1), .load_tens(lt1), .count_ones(o1), .count_tens(t1),
      .busy(b1), .done(d1), .load_err(e1));

   bcd_countdown_timer #(.TICK_DIV(4)) dut4 (
      .clock(clock), .reset(reset), .start(start4), .pause(pause4), .abort(abort4),
      .load_ones(lo4), .load_tens(lt4), .count_ones(o4), .count_tens(t4),
      .busy(b4), .done(d4), .load_err(e4));

   function automatic vec_t mk(input string n, input logic r, input logic s, input logic p,
                               input logic a, input logic [3:0] lt, input logic [3:0] lo,
                               input logic [3:0] et, input logic [3:0] eo,
                               input logic b, input logic d, input logic e);
      vec_t v;
      v.name = n; v.rst = r; v.st = s; v.pa = p; v.ab = a;
      v.lt = lt; v.lo = lo; v.et = et; v.eo = eo; v.eb = b; v.ed = d; v.ee = e;
      return v;
   endfunction

   task automatic step(input int which, input vec_t v);
      vec_t        x;
      logic [10:0] got;
      logic [10:0] want;
      @(negedge clock);
      reset  = v.rst;
      start1 = (which == 1) ? v.st : 1'b0;
      pause1 = (which == 1) ? v.pa : 1'b0;
      abort1 = (which == 1) ? v.ab : 1'b0;
      lt1    = (which == 1) ? v.lt : 4'd0;
      lo1    = (which == 1) ? v.lo : 4'd0;
      start4 = (which == 4) ? v.st : 1'b0;
      pause4 = (which == 4) ? v.pa : 1'b0;
      abort4 = (which == 4) ? v.ab : 1'b0;
      lt4    = (which == 4) ? v.lt : 4'd0;
      lo4    = (which == 4) ? v.lo : 4'd0;
      sb.push_back(v);
      @(posedge clock);
      #1;
      x    = sb.pop_front();
      got  = (which == 1) ? {t1, o1, b1, d1, e1} : {t4, o4, b4, d4, e4};
      want = {x.et, x.eo, x.eb, x.ed, x.ee};
      applied++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s (dut%0d): got tens=%0d ones=%0d busy=%b done=%b err=%b, expected tens=%0d ones=%0d busy=%b done=%b err=%b",
                  x.name, which, got[10:7], got[6:3], got[2], got[1], got[0],
                  x.et, x.eo, x.eb, x.ed, x.ee);
      end
   endtask

   initial begin
      int n;
      //                name         rst st pa ab lt    lo    et eo b  d  e
      tbl.push_back(mk("rst_ovr",    1, 1, 0, 0, 0,    3,    0, 0, 0, 0, 0));
      tbl.push_back(mk("rst_rel",    0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("idle_hold",  0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld03",       0, 1, 0, 0, 0,    3,    0, 3, 1, 0, 0));
      tbl.push_back(mk("c02",        0, 0, 0, 0, 0,    0,    0, 2, 1, 0, 0));
      tbl.push_back(mk("c01",        0, 0, 0, 0, 0,    0,    0, 1, 1, 0, 0));
      tbl.push_back(mk("c00_done",   0, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0));
      tbl.push_back(mk("after_done", 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("err_onesA",  0, 1, 0, 0, 0,    4'hA, 0, 0, 0, 0, 1));
      tbl.push_back(mk("err_clear",  0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("err_tensC",  0, 1, 0, 0, 4'hC, 1,    0, 0, 0, 0, 1));
      tbl.push_back(mk("err_clr2",   0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld00_done",  0, 1, 0, 0, 0,    0,    0, 0, 0, 1, 0));
      tbl.push_back(mk("ld00_idle",  0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld57",       0, 1, 0, 0, 5,    7,    5, 7, 1, 0, 0));
      tbl.push_back(mk("abort57",    0, 0, 0, 1, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("abort_idle", 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld12",       0, 1, 0, 0, 1,    2,    1, 2, 1, 0, 0));
      tbl.push_back(mk("st_in_run",  0, 1, 0, 0, 9,    9,    1, 1, 1, 0, 0));
      tbl.push_back(mk("st_in_run2", 0, 1, 0, 0, 0,    5,    1, 0, 1, 0, 0));
      tbl.push_back(mk("borrow09",   0, 0, 0, 0, 0,    0,    0, 9, 1, 0, 0));
      tbl.push_back(mk("pause09",    0, 0, 1, 0, 0,    0,    0, 9, 1, 0, 0));
      tbl.push_back(mk("abort_pau",  0, 0, 1, 1, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("abort_ign",  0, 0, 0, 1, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld42",       0, 1, 0, 0, 4,    2,    4, 2, 1, 0, 0));
      tbl.push_back(mk("rst_run",    1, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("rst_rel2",   0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld01",       0, 1, 0, 0, 0,    1,    0, 1, 1, 0, 0));
      tbl.push_back(mk("ld01_done",  0, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0));
      tbl.push_back(mk("ld01_idle",  0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld30",       0, 1, 0, 0, 3,    0,    3, 0, 1, 0, 0));
      tbl.push_back(mk("pause30",    0, 0, 1, 0, 0,    0,    3, 0, 1, 0, 0));
      tbl.push_back(mk("rst_pause",  1, 0, 1, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("rst_rel3",   0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));
      tbl.push_back(mk("ld02",       0, 1, 0, 0, 0,    2,    0, 2, 1, 0, 0));
      tbl.push_back(mk("p02a",       0, 0, 1, 0, 0,    0,    0, 2, 1, 0, 0));
      tbl.push_back(mk("p02b",       0, 0, 1, 0, 0,    0,    0, 2, 1, 0, 0));
      tbl.push_back(mk("resume01",   0, 0, 0, 0, 0,    0,    0, 1, 1, 0, 0));
      tbl.push_back(mk("resume00",   0, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0));
      tbl.push_back(mk("resume_idl", 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) step(1, tbl[i]);

      // full 20 -> 00 run with tens borrow
      step(1, mk("ld20", 0, 1, 0, 0, 2, 0, 2, 0, 1, 0, 0));
      for (int k = 1; k <= 20; k++) begin
         n = 20 - k;
         step(1, mk($sformatf("dn%0d", n), 0, 0, 0, 0, 0, 0, 4'(n / 10), 4'(n % 10),
                    n != 0, n == 0, 0));
      end
      step(1, mk("dn_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // TICK_DIV=4 reference run: 02 for 4 edges after load, 01 for 4, then 00
      step(4, mk("d4_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(4, mk("d4_ld02", 0, 1, 0, 0, 0, 2, 0, 2, 1, 0, 0));
      for (int k = 1; k <= 3; k++) step(4, mk($sformatf("d4_hold02_%0d", k), 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      for (int k = 4; k <= 7; k++) step(4, mk($sformatf("d4_hold01_%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      step(4, mk("d4_done8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step(4, mk("d4_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // same run with pause held 3 cycles after the first decrement: 00 lands 3 edges later
      step(4, mk("d4p_ld02", 0, 1, 0, 0, 0, 2, 0, 2, 1, 0, 0));
      for (int k = 1; k <= 3; k++) step(4, mk($sformatf("d4p_hold02_%0d", k), 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      step(4, mk("d4p_dec01", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      for (int k = 1; k <= 3; k++) step(4, mk($sformatf("d4p_paused_%0d", k), 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      for (int k = 1; k <= 3; k++) step(4, mk($sformatf("d4p_run01_%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      step(4, mk("d4p_done11", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step(4, mk("d4p_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
